tmr_adder_pipe: RTL
===================

Name: tmr_adder_pipe

Overview:
- Pipelined, parametrised triple-modular-redundant adder with input integrity checking.
- Accepts operand pairs plus a one-hot control word over a valid/ready handshake. Control selects carry-in and operand inversion.
- Computes the result in three replicas and majority-votes it. Reports corrected, uncorrectable and input-integrity errors.
- Keeps a sticky per-replica fault map and a saturating error counter. Sits between an operand source and a result sink in the datapath.

Parameters:
- WIDTH, 3, operand and sum width in bits (>=2).
- CNT_W, 8, error counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- par  in  1  parity bit. Valid beat: popcount(a,b,par) is odd.
- ctrl  in  3  one-hot control.
  - ctrl[0]=1 -> cin=0, else cin=1.
  - ctrl[1] inverts b.
  - ctrl[2] inverts a.
- inj  in  3  fault injection. inj[i]=1 flips sum bit (i mod WIDTH) of replica i.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- sum  out  WIDTH  voted sum.
- cout  out  1  voted carry-out.
- err  out  2  result status.
  - 00 ok.
  - 01 single replica disagreed, corrected.
  - 10 input error.
  - 11 all replicas differ.
- fault_id  out  3  sticky; bit i set when replica i was the outvoted one.
- err_cnt  out  CNT_W  saturating count of beats with err!=00.
- clr  in  1  synchronous clear of fault_id and err_cnt.

Behaviour:
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, err=00, fault_id=0, err_cnt=0. All pipeline valids are cleared.
- Reset mid-operation discards in-flight beats, with no partial outputs.
- Stage S1 register: captures a, b, par, ctrl and inj on in_valid&&in_ready. It also computes the parity_ok and onehot_ok flags from the captured inputs.
- Replica datapath: combinational from S1.
  - ai = a ^ {WIDTH{ctrl[2]}}.
  - bi = b ^ {WIDTH{ctrl[1]}}.
  - {cout_i,sum_i} = ai + bi + cin, then the inj flip is applied.
  - Each replica is a separate instance; synthesis must not merge them.
- Stage S2 register: captures the three {cout,sum} replica results plus the input-check flags.
- Voter and outputs: combinational from S2.
  - Input check failed: err=10, sum=0, cout=0. Takes priority over the vote.
  - All three agree: err=00, output that value.
  - Exactly two agree: output the majority value, err=01.
  - All three differ: output replica 0, err=11, fault_id unchanged.
- Latency: out_valid rises 2 cycles after acceptance when not stalled. Throughput is 1 beat/cycle.
- Handshake:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = !s1_valid || S2 advances.
  - out_valid = s2_valid.
  - Outputs hold stable while out_valid && !out_ready.
  - Order is preserved and no beat is dropped or duplicated.
- Error bookkeeping:
  - Updated at the out_valid&&out_ready transfer, once per beat.
  - err=01 sets the fault_id bit of the outvoted replica.
  - err!=00 increments err_cnt, which saturates with no wrap.
  - clr zeroes both. clr has priority over a same-cycle update.
- Arithmetic is modulo 2^WIDTH, with the carry reported in cout.

Decomposition:
- Shared package (tmr_pkg):
  - ERR_OK=2'b00, ERR_CORR=2'b01, ERR_INPUT=2'b10, ERR_UNCORR=2'b11.
  - One-hot check function: exactly one bit set.
- Natural sub-module: tmr_replica, one per redundant copy (parametrised WIDTH, inj bit index).
- Pipeline and voter stay in the top level.

Test Plan:
- a=3, b=2, par=0, ctrl=001 -> 2 cycles later sum=5, cout=0, err=00.
- ctrl=010, a=3, b=2, par=0 -> sum=1, cout=1, err=00. Then ctrl=100 -> sum=7, cout=0, err=00.
- a=3, b=2, ctrl=001, inj=010 -> sum=5, err=01, fault_id=010, err_cnt=1. Then inj=011 -> sum=4 (replica 0), err=11, fault_id stays 010, err_cnt=2.
- Input errors:
  - par=1, a=3, b=2, ctrl=001 -> err=10, sum=0.
  - ctrl=011 with good parity -> err=10.
  - ctrl=000 with good parity -> err=10.
- Back-to-back beats 5 in, out_ready=0 for 4 cycles:
  - in_ready falls after 2 beats accepted.
  - Outputs stay stable.
  - All 5 results then emerge in order, one per cycle, with no loss.
- Saturation, clr and reset:
  - CNT_W=2 with 5 injected errors -> err_cnt stops at 3.
  - clr -> err_cnt=0, fault_id=0.
  - Asserting rst with 2 beats in flight -> out_valid=0 immediately and no stale result after release.

Source files
------------

// File: rtl/tmr_adder_pipe_pkg.sv
// Shared definitions for the triple-modular-redundant adder pipeline:
// result status codes and the control-word integrity check.
package tmr_pkg;

    typedef enum logic [1:0] {
        ERR_OK     = 2'b00,
        ERR_CORR   = 2'b01,
        ERR_INPUT  = 2'b10,
        ERR_UNCORR = 2'b11
    } err_t;

    function automatic logic is_onehot3(input logic [2:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/tmr_adder_pipe_if.sv
// Operand/result bus of the TMR adder: one valid/ready channel in, one out.
interface tmr_adder_pipe_if #(
    parameter int WIDTH = 3
);
    // Both channels: a beat transfers on a rising clock edge where valid and
    // ready are both high; the sender holds valid and its payload stable until
    // then, and ready never depends on valid of the same channel.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             par;
    logic [2:0]       ctrl;
    logic [2:0]       inj;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       err;

    modport master (
        output in_valid, a, b, par, ctrl, inj, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, a, b, par, ctrl, inj, out_ready,
        output in_ready, out_valid, sum, cout, err
    );
endinterface

// File: rtl/tmr_adder_pipe_replica.sv
// One redundant copy of the adder datapath; its inj input flips one sum bit
// so that the voter downstream can be exercised.
module tmr_replica #(
    parameter int WIDTH   = 3,
    parameter int INJ_BIT = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             cin,
    input  logic             inj,
    output logic [WIDTH:0]   res
);
    localparam logic [WIDTH:0] FLIP = (WIDTH+1)'(1) << INJ_BIT;

    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH:0]   raw;

    assign ai  = a ^ {WIDTH{inv_a}};
    assign bi  = b ^ {WIDTH{inv_b}};
    assign raw = {1'b0, ai} + {1'b0, bi} + (WIDTH+1)'(cin);
    assign res = raw ^ (inj ? FLIP : '0);
endmodule

// File: rtl/tmr_adder_pipe.sv
// Two-stage TMR adder: S1 holds the operand beat, three replicas add it,
// S2 holds their results, and a majority voter drives the result channel.
module tmr_adder_pipe
    import tmr_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    tmr_adder_pipe_if.slave    bus,
    input  logic               clr,
    output logic [2:0]         fault_id,
    output logic [CNT_W-1:0]   err_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_par;
    logic [2:0]       s1_ctrl;
    logic [2:0]       s1_inj;
    logic             s2_valid;
    logic [WIDTH:0]   s2_res [3];
    logic             s2_in_bad;
    logic [WIDTH:0]   rep_res [3];
    logic             s1_adv;
    logic             s2_adv;
    logic             in_ok;
    logic             xfer;
    logic [WIDTH:0]   vote_res;
    err_t             vote_err;
    logic [2:0]       outvoted;

    assign s2_adv        = !s2_valid || bus.out_ready;
    assign s1_adv        = !s1_valid || s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign xfer          = s2_valid && bus.out_ready;
    assign in_ok         = (^{s1_a, s1_b, s1_par}) && is_onehot3(s1_ctrl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_par   <= 1'b0;
            s1_ctrl  <= '0;
            s1_inj   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a    <= bus.a;
                s1_b    <= bus.b;
                s1_par  <= bus.par;
                s1_ctrl <= bus.ctrl;
                s1_inj  <= bus.inj;
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_rep
        tmr_replica #(
            .WIDTH   (WIDTH),
            .INJ_BIT (i % WIDTH)
        ) u_rep (
            .a     (s1_a),
            .b     (s1_b),
            .inv_a (s1_ctrl[2]),
            .inv_b (s1_ctrl[1]),
            .cin   (~s1_ctrl[0]),
            .inj   (s1_inj[i]),
            .res   (rep_res[i])
        );
    end

    // Idle S2 holds identical zero results, so the outputs read 0 / ERR_OK out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_res    <= '{default: '0};
            s2_in_bad <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res    <= rep_res;
                s2_in_bad <= !in_ok;
            end
        end
    end

    always_comb begin
        vote_res = s2_res[0];
        vote_err = ERR_OK;
        outvoted = 3'b000;
        if (s2_in_bad) begin
            vote_res = '0;
            vote_err = ERR_INPUT;
        end else if (s2_res[0] == s2_res[1] && s2_res[1] == s2_res[2]) begin
            vote_err = ERR_OK;
        end else if (s2_res[0] == s2_res[1]) begin
            vote_err = ERR_CORR;
            outvoted = 3'b100;
        end else if (s2_res[0] == s2_res[2]) begin
            vote_err = ERR_CORR;
            outvoted = 3'b010;
        end else if (s2_res[1] == s2_res[2]) begin
            vote_res = s2_res[1];
            vote_err = ERR_CORR;
            outvoted = 3'b001;
        end else begin
            vote_err = ERR_UNCORR;
        end
    end

    assign bus.sum  = vote_res[WIDTH-1:0];
    assign bus.cout = vote_res[WIDTH];
    assign bus.err  = vote_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_id <= '0;
            err_cnt  <= '0;
        end else if (clr) begin
            fault_id <= '0;
            err_cnt  <= '0;
        end else if (xfer) begin
            if (vote_err == ERR_CORR) begin
                fault_id <= fault_id | outvoted;
            end
            if (vote_err != ERR_OK && err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule
